spike_rate_decoder: RTL and testbench

Read-side counterpart to the LIF neuron. Samples a neuron's 1-bit `spike` output over fixed windows of clock cycles and produces, per window, the spike count (rate code) and the first-spike latency (time-to-first-spike code). Results leave through a valid/ready output port so a downstream classifier or host register can consume them.

---
 rtl/spike_rate_decoder.sv | 151 +++++++++++++++
 tb/tb_spike_rate_decoder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_decoder.sv
// ============================================================================
// spike_rate_decoder
// Windowed spike-count (rate) and first-spike-latency decoder with a
// valid/ready result port and a sticky overrun flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module spike_rate_decoder #(
  parameter int WINDOW_W = 8,
  parameter int COUNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                spike,
  input  logic [WINDOW_W-1:0] window_len,
  output logic [COUNT_W-1:0]  rate,
  output logic [WINDOW_W-1:0] first_lat,
  output logic                silent,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overrun
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nx;

  logic [WINDOW_W-1:0] len_q;
  logic [WINDOW_W-1:0] cyc;
  logic [COUNT_W-1:0]  cnt;
  logic [WINDOW_W-1:0] lat;
  logic                seen;

  logic [WINDOW_W-1:0] last_cyc;
  logic                win_close;
  logic [COUNT_W-1:0]  cnt_fin;
  logic [WINDOW_W-1:0] lat_fin;
  logic                seen_fin;
  logic                publish;
  logic                drop;
  logic                xfer;

  // Modular subtraction makes len_q=0 close at the all-ones cycle index.
  assign last_cyc  = len_q - 1'b1;
  assign win_close = (state == RUN) && (cyc == last_cyc);

  // Per-cycle accumulator values including the spike sampled this cycle.
  assign cnt_fin  = (spike && (cnt != {COUNT_W{1'b1}})) ? cnt + 1'b1 : cnt;
  assign seen_fin = seen | spike;
  assign lat_fin  = (spike && !seen) ? cyc : lat;

  assign xfer    = out_valid && out_ready;
  assign publish = win_close && (!out_valid || out_ready);
  assign drop    = win_close && out_valid && !out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (en) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        if (win_close) begin
          state_nx = en ? RUN : IDLE;
        end else if (!en) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q <= '0;
      cyc   <= '0;
      cnt   <= '0;
      lat   <= '0;
      seen  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            len_q <= window_len;
            cyc   <= '0;
            cnt   <= '0;
            seen  <= 1'b0;
          end
        end
        RUN: begin
          // Close and abort both restart the accumulators; an abort's re-latch
          // is harmless because IDLE loads len_q again on the next start.
          if (win_close || !en) begin
            len_q <= window_len;
            cyc   <= '0;
            cnt   <= '0;
            seen  <= 1'b0;
          end else begin
            cyc  <= cyc + 1'b1;
            cnt  <= cnt_fin;
            lat  <= lat_fin;
            seen <= seen_fin;
          end
        end
        default: begin
          cyc <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rate      <= '0;
      first_lat <= '0;
      silent    <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (publish) begin
        rate      <= cnt_fin;
        first_lat <= seen_fin ? lat_fin : '0;
        silent    <= !seen_fin;
        out_valid <= 1'b1;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
      if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spike_rate_decoder.sv
// ============================================================================
// tb_spike_rate_decoder
// Directed self-checking bench for spike_rate_decoder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_spike_rate_decoder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       spike;
  logic [7:0] window_len;
  logic [7:0] rate;
  logic [7:0] first_lat;
  logic       silent;
  logic       out_valid;
  logic       out_ready;
  logic       overrun;

  int checks;
  int failures;

  spike_rate_decoder #(
    .WINDOW_W(8),
    .COUNT_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .spike     (spike),
    .window_len(window_len),
    .rate      (rate),
    .first_lat (first_lat),
    .silent    (silent),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector layout: {out_valid, rate, first_lat, silent, overrun}.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    en         = 1'b0;
    spike      = 1'b0;
    out_ready  = 1'b0;
    window_len = 8'd0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic start(input logic [7:0] len);
    window_len = len;
    en         = 1'b1;
    spike      = 1'b0;
    tick();
  endtask

  task automatic drive(input logic [255:0] pat, input int from, input int to);
    for (int k = from; k <= to; k++) begin
      spike = pat[k];
      tick();
    end
    spike = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; spike = 1'b1; out_ready = 1'b1; window_len = 8'd10;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({out_valid, rate, first_lat, silent, overrun} !== 19'd0) begin
        failures++;
        $display("FAIL reset_hold[%0d] got=%h exp=%h", i,
                 {out_valid, rate, first_lat, silent, overrun}, 19'd0);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_start_delay out_valid got=%b exp=0", out_valid);
    end
    tick();
    checks++;
    if ({out_valid, rate, first_lat, silent, overrun} !== {1'b1, 8'd10, 8'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_first_window got=%h exp=%h",
               {out_valid, rate, first_lat, silent, overrun}, {1'b1, 8'd10, 8'd0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_basic();
    do_reset();
    out_ready = 1'b1;
    start(8'd10);
    drive(256'h2A8, 0, 8);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_early_valid got=%b exp=0", out_valid);
    end
    drive(256'h2A8, 9, 9);
    checks++;
    if ({out_valid, rate, first_lat, silent, overrun} !== {1'b1, 8'd4, 8'd3, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL basic_win1 got=%h exp=%h",
               {out_valid, rate, first_lat, silent, overrun}, {1'b1, 8'd4, 8'd3, 1'b0, 1'b0});
    end
    drive(256'h2A8, 0, 0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_valid_pulse got=%b exp=0", out_valid);
    end
    drive(256'h2A8, 1, 9);
    checks++;
    if ({out_valid, rate, first_lat, silent, overrun} !== {1'b1, 8'd4, 8'd3, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL basic_win2 got=%h exp=%h",
               {out_valid, rate, first_lat, silent, overrun}, {1'b1, 8'd4, 8'd3, 1'b0, 1'b0});
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_silent_saturate();
    do_reset();
    out_ready = 1'b1;
    start(8'd4);
    drive(256'h0, 0, 3);
    checks++;
    if ({out_valid, rate, first_lat, silent, overrun} !== {1'b1, 8'd0, 8'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL silent_win got=%h exp=%h",
               {out_valid, rate, first_lat, silent, overrun}, {1'b1, 8'd0, 8'd0, 1'b1, 1'b0});
    end
    en = 1'b0;
    tick();
    start(8'd0);
    drive({256{1'b1}}, 0, 254);
    checks++;
    if ({out_valid, rate, first_lat, silent, overrun} !== {1'b0, 8'd0, 8'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL sat_before_close got=%h exp=%h",
               {out_valid, rate, first_lat, silent, overrun}, {1'b0, 8'd0, 8'd0, 1'b1, 1'b0});
    end
    drive({256{1'b1}}, 255, 255);
    checks++;
    if ({out_valid, rate, first_lat, silent, overrun} !== {1'b1, 8'd255, 8'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL sat_win got=%h exp=%h",
               {out_valid, rate, first_lat, silent, overrun}, {1'b1, 8'd255, 8'd0, 1'b0, 1'b0});
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    start(8'd5);
    drive(256'h6, 0, 4);
    checks++;
    if ({out_valid, rate, first_lat, silent, overrun} !== {1'b1, 8'd2, 8'd1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL bp_win1 got=%h exp=%h",
               {out_valid, rate, first_lat, silent, overrun}, {1'b1, 8'd2, 8'd1, 1'b0, 1'b0});
    end
    drive(256'h1F, 0, 4);
    checks++;
    if ({out_valid, rate, first_lat, silent, overrun} !== {1'b1, 8'd2, 8'd1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL bp_drop got=%h exp=%h",
               {out_valid, rate, first_lat, silent, overrun}, {1'b1, 8'd2, 8'd1, 1'b0, 1'b1});
    end
    out_ready = 1'b1;
    drive(256'h10, 0, 0);
    out_ready  = 1'b0;
    window_len = 8'd2;
    checks++;
    if ({out_valid, rate, first_lat, silent, overrun} !== {1'b0, 8'd2, 8'd1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL bp_drain got=%h exp=%h",
               {out_valid, rate, first_lat, silent, overrun}, {1'b0, 8'd2, 8'd1, 1'b0, 1'b1});
    end
    drive(256'h10, 1, 3);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_len_change_early got=%b exp=0", out_valid);
    end
    drive(256'h10, 4, 4);
    checks++;
    if ({out_valid, rate, first_lat, silent, overrun} !== {1'b1, 8'd1, 8'd4, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL bp_win3 got=%h exp=%h",
               {out_valid, rate, first_lat, silent, overrun}, {1'b1, 8'd1, 8'd4, 1'b0, 1'b1});
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    do_reset();
    out_ready = 1'b1;
    start(8'd8);
    drive(256'h3, 0, 1);
    en    = 1'b0;
    spike = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if ({out_valid, rate, first_lat, silent, overrun} !== 19'd0) begin
      failures++;
      $display("FAIL abort_no_publish got=%h exp=%h",
               {out_valid, rate, first_lat, silent, overrun}, 19'd0);
    end
    start(8'd8);
    drive(256'h20, 0, 7);
    checks++;
    if ({out_valid, rate, first_lat, silent, overrun} !== {1'b1, 8'd1, 8'd5, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL abort_fresh_win got=%h exp=%h",
               {out_valid, rate, first_lat, silent, overrun}, {1'b1, 8'd1, 8'd5, 1'b0, 1'b0});
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b0;
    start(8'd3);
    drive(256'h4, 0, 2);
    checks++;
    if ({out_valid, rate, first_lat, silent, overrun} !== {1'b1, 8'd1, 8'd2, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL b2b_win1 got=%h exp=%h",
               {out_valid, rate, first_lat, silent, overrun}, {1'b1, 8'd1, 8'd2, 1'b0, 1'b0});
    end
    drive(256'h7, 0, 1);
    checks++;
    if ({out_valid, rate, first_lat, silent, overrun} !== {1'b1, 8'd1, 8'd2, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL b2b_hold got=%h exp=%h",
               {out_valid, rate, first_lat, silent, overrun}, {1'b1, 8'd1, 8'd2, 1'b0, 1'b0});
    end
    out_ready = 1'b1;
    en        = 1'b0;
    drive(256'h7, 2, 2);
    checks++;
    if ({out_valid, rate, first_lat, silent, overrun} !== {1'b1, 8'd3, 8'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL b2b_close_xfer got=%h exp=%h",
               {out_valid, rate, first_lat, silent, overrun}, {1'b1, 8'd3, 8'd0, 1'b0, 1'b0});
    end
    spike = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    spike = 1'b0;
    checks++;
    if ({out_valid, rate, first_lat, silent, overrun} !== {1'b0, 8'd3, 8'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL b2b_idle_after got=%h exp=%h",
               {out_valid, rate, first_lat, silent, overrun}, {1'b0, 8'd3, 8'd0, 1'b0, 1'b0});
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n = 1'b0; en = 1'b0; spike = 1'b0; out_ready = 1'b0; window_len = 8'd0;
    test_reset();
    test_basic();
    test_silent_saturate();
    test_backpressure();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
